// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the triggered ADC capture stage: stream and length
// widths that must line up with the rest of the RFSoC datapath, and the
// capture controller state encoding.
package adc_capture_ctrl_pkg;

    // Width of one ADC AXI-Stream word coming from the ADC controller
    localparam int ADC_AXIS_WIDTH    = 128;

    // Width of the programmable capture length
    localparam int CAPTURE_LEN_WIDTH = 16;

    // Width of the free-running timestamp counter
    localparam int TIMESTAMP_WIDTH   = 64;

    // Capture controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        ABORT   = 2'd3
    } capture_state_t;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// AXI-Stream style bundle used for the packetised capture output.
// The master drives data/valid/last, the slave answers with ready.
interface adc_capture_ctrl_if
    import adc_capture_ctrl_pkg::*;
#(
    parameter int DATA_W = ADC_AXIS_WIDTH
);

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/adc_capture_ctrl_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head entry is always
// visible on rd_data while the FIFO is non-empty; rd_en acts as a pop.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter. DEPTH must be a power of two (>= 2).
module sync_fifo_fwft
    import adc_capture_ctrl_pkg::*;
#(
    parameter int WIDTH = ADC_AXIS_WIDTH + 1,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_write;
    logic             do_read;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the head slot in the same cycle, so a write is allowed
    // into a full FIFO only when it is paired with a read.
    assign do_read  = rd_en && !empty;
    assign do_write = wr_en && (!full || do_read);

    assign rd_data  = mem[rd_ptr[AW-1:0]];

    // Storage array; not reset because the pointers define what is valid
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; reset flushes the FIFO by re-aligning both pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered capture stage in front of the PL-to-PS width converter.
// Once armed and triggered it copies a programmed number of ADC words into
// a FWFT FIFO tagged with a last flag, and replays them as one AXI-Stream
// packet. If the FIFO fills mid-capture the packet is closed early with an
// all-zero terminator word so downstream always sees exactly one tlast.
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
#(
    parameter int DATA_W     = ADC_AXIS_WIDTH,
    parameter int FIFO_DEPTH = 512,
    parameter int LEN_W      = CAPTURE_LEN_WIDTH,
    parameter int TS_W       = TIMESTAMP_WIDTH
) (
    input  logic              pl_clk,
    input  logic              rst,

    input  logic [DATA_W-1:0] adc_tdata,
    input  logic              adc_tvalid,

    input  logic              arm,
    input  logic              trigger,
    input  logic [LEN_W-1:0]  capture_len,

    adc_capture_ctrl_if.master m_axis,

    output logic [TS_W-1:0]   trig_timestamp,
    output logic              busy,
    output logic              overflow,
    output logic              done
);

    capture_state_t    state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  count;
    logic [TS_W-1:0]   timestamp;

    logic              fifo_wr_en;
    logic [DATA_W:0]   fifo_wr_data;
    logic              fifo_rd_en;
    logic [DATA_W:0]   fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;

    logic              last_word;
    logic              accept_arm;

    // count is cleared on arm, so the same compare marks the final word
    // both for the trigger-cycle write and for later writes.
    assign last_word  = (count == len - LEN_W'(1));
    assign accept_arm = arm && (capture_len != '0) && fifo_empty;

    sync_fifo_fwft #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (pl_clk),
        .rst     (rst),
        .wr_en   (fifo_wr_en),
        .wr_data (fifo_wr_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output stream is the FIFO head; data and last are held at zero while
    // empty so nothing stale is presented after reset or between packets.
    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tdata  = fifo_empty ? '0 : fifo_rd_data[DATA_W-1:0];
    assign m_axis.tlast  = !fifo_empty && fifo_rd_data[DATA_W];
    assign fifo_rd_en    = m_axis.tready;

    assign busy = (state != IDLE) || !fifo_empty;

    // FIFO write selection: captured ADC words, or the abort terminator
    always_comb begin
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        case (state)
            ARMED: begin
                if (trigger && adc_tvalid && !fifo_full) begin
                    fifo_wr_en   = 1'b1;
                    fifo_wr_data = {last_word, adc_tdata};
                end
            end
            CAPTURE: begin
                if (adc_tvalid && !fifo_full) begin
                    fifo_wr_en   = 1'b1;
                    fifo_wr_data = {last_word, adc_tdata};
                end
            end
            ABORT: begin
                if (!fifo_full) begin
                    fifo_wr_en   = 1'b1;
                    fifo_wr_data = {1'b1, {DATA_W{1'b0}}};
                end
            end
            default: begin
            end
        endcase
    end

    // Capture controller: arm/trigger sequencing, word counting, overflow
    always_ff @(posedge pl_clk) begin
        if (rst) begin
            state          <= IDLE;
            len            <= '0;
            count          <= '0;
            overflow       <= 1'b0;
            trig_timestamp <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_arm) begin
                        len      <= capture_len;
                        count    <= '0;
                        overflow <= 1'b0;
                        state    <= ARMED;
                    end
                end

                ARMED: begin
                    if (trigger) begin
                        trig_timestamp <= timestamp;
                        state          <= CAPTURE;
                        if (adc_tvalid) begin
                            if (fifo_full) begin
                                overflow <= 1'b1;
                                state    <= ABORT;
                            end else if (last_word) begin
                                state <= IDLE;
                            end else begin
                                count <= count + LEN_W'(1);
                            end
                        end
                    end
                end

                CAPTURE: begin
                    if (adc_tvalid) begin
                        if (fifo_full) begin
                            overflow <= 1'b1;
                            state    <= ABORT;
                        end else if (last_word) begin
                            state <= IDLE;
                        end else begin
                            count <= count + LEN_W'(1);
                        end
                    end
                end

                ABORT: begin
                    if (!fifo_full) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running timestamp, wraps naturally at 2^TS_W
    always_ff @(posedge pl_clk) begin
        if (rst) begin
            timestamp <= '0;
        end else begin
            timestamp <= timestamp + TS_W'(1);
        end
    end

    // done pulses in the cycle after the tlast word is accepted downstream
    always_ff @(posedge pl_clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= m_axis.tvalid && m_axis.tready && m_axis.tlast;
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: table-driven single-cycle vectors for the
// basic capture, ignored-arm and single-word cases, then hand-written
// sequences for the deferred trigger, FIFO overflow/abort and reset
// mid-capture. A small FIFO depth keeps the overflow case short.
module tb_adc_capture_ctrl;
    import adc_capture_ctrl_pkg::*;

    localparam int DATA_W     = ADC_AXIS_WIDTH;
    localparam int FIFO_DEPTH = 8;
    localparam int LEN_W      = CAPTURE_LEN_WIDTH;
    localparam int TS_W       = TIMESTAMP_WIDTH;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic              pl_clk;
    logic              rst;
    logic [DATA_W-1:0] adc_tdata;
    logic              adc_tvalid;
    logic              arm;
    logic              trigger;
    logic [LEN_W-1:0]  capture_len;
    logic [TS_W-1:0]   trig_timestamp;
    logic              busy;
    logic              overflow;
    logic              done;

    logic [TS_W-1:0]   ref_ts;
    logic [TS_W-1:0]   snap_ts;
    logic [DATA_W-1:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic              arm;
        logic              trigger;
        logic [LEN_W-1:0]  len;
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              ready;
        logic              e_tvalid;
        logic [DATA_W-1:0] e_tdata;
        logic              e_tlast;
        logic              e_busy;
        logic              e_done;
        logic              e_ovf;
    } vec_t;

    vec_t vecs [$];

    adc_capture_ctrl_if #(.DATA_W(DATA_W)) m_axis ();

    adc_capture_ctrl #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEN_W      (LEN_W),
        .TS_W       (TS_W)
    ) dut (
        .pl_clk         (pl_clk),
        .rst            (rst),
        .adc_tdata      (adc_tdata),
        .adc_tvalid     (adc_tvalid),
        .arm            (arm),
        .trigger        (trigger),
        .capture_len    (capture_len),
        .m_axis         (m_axis),
        .trig_timestamp (trig_timestamp),
        .busy           (busy),
        .overflow       (overflow),
        .done           (done)
    );

    initial pl_clk = 1'b0;
    always #5 pl_clk = ~pl_clk;

    // Reference cycle counter: the value expected in the timestamp counter
    always @(posedge pl_clk) begin
        if (rst) ref_ts <= '0;
        else     ref_ts <= ref_ts + TS_W'(1);
    end

    // Hard time limit so the bench never hangs
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge pl_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic a, input logic t, input logic [LEN_W-1:0] l,
                                 input logic v, input logic [DATA_W-1:0] d, input logic r);
        arm           = a;
        trigger       = t;
        capture_len   = l;
        adc_tvalid    = v;
        adc_tdata     = d;
        m_axis.tready = r;
    endtask

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checkOutput(name, DATA_W'(act), DATA_W'(exp));
    endtask

    // Drain exp_q through the output with tready high, then expect done
    task automatic collect_packet(input string name);
        int n;
        n = exp_q.size();
        applyStimulus(L, L, '0, L, '0, H);
        for (int i = 0; i < n; i++) begin
            int waits = 0;
            while (!m_axis.tvalid && waits < 20) begin
                tick();
                waits++;
            end
            if (!m_axis.tvalid) begin
                total++;
                bad++;
                $display("[TB] FAIL %s word%0d timeout: got tvalid=0 expected tvalid=1", name, i);
                return;
            end
            checkOutput($sformatf("%s word%0d data", name, i), m_axis.tdata, exp_q[i]);
            check_bit($sformatf("%s word%0d tlast", name, i), m_axis.tlast, i == n - 1);
            tick();
        end
        check_bit({name, " done"}, done, H);
        check_bit({name, " busy after drain"}, busy, L);
    endtask

    function automatic vec_t make_vec(input logic a, input logic t, input logic [LEN_W-1:0] l,
                                      input logic v, input logic [DATA_W-1:0] d, input logic r,
                                      input logic etv, input logic [DATA_W-1:0] etd,
                                      input logic etl, input logic eb, input logic ed,
                                      input logic eo);
        vec_t x;
        x.arm = a;  x.trigger = t;  x.len = l;  x.valid = v;  x.data = d;  x.ready = r;
        x.e_tvalid = etv;  x.e_tdata = etd;  x.e_tlast = etl;
        x.e_busy = eb;  x.e_done = ed;  x.e_ovf = eo;
        return x;
    endfunction

    initial begin
        // arm trig len valid data ready | tvalid tdata tlast busy done ovf
        // len=4 capture with continuous data and tready high
        vecs.push_back(make_vec(H, L, 16'd4, H, 128'h99, H,  L, 128'h0, L, H, L, L));
        vecs.push_back(make_vec(L, H, 16'd0, H, 128'h1,  H,  H, 128'h1, L, H, L, L));
        vecs.push_back(make_vec(L, L, 16'd0, H, 128'h2,  H,  H, 128'h2, L, H, L, L));
        vecs.push_back(make_vec(L, L, 16'd0, H, 128'h3,  H,  H, 128'h3, L, H, L, L));
        vecs.push_back(make_vec(L, L, 16'd0, H, 128'h4,  H,  H, 128'h4, H, H, L, L));
        vecs.push_back(make_vec(L, L, 16'd0, H, 128'h5,  H,  L, 128'h0, L, L, H, L));
        vecs.push_back(make_vec(L, L, 16'd0, L, 128'h0,  H,  L, 128'h0, L, L, L, L));
        // arm with len=0 ignored, so a following trigger captures nothing
        vecs.push_back(make_vec(H, L, 16'd0, H, 128'h77, H,  L, 128'h0, L, L, L, L));
        vecs.push_back(make_vec(L, H, 16'd0, H, 128'h78, H,  L, 128'h0, L, L, L, L));
        // len=2 held in the FIFO, then an arm while non-empty is ignored
        vecs.push_back(make_vec(H, L, 16'd2, L, 128'h0,  L,  L, 128'h0,  L, H, L, L));
        vecs.push_back(make_vec(L, H, 16'd0, H, 128'h21, L,  H, 128'h21, L, H, L, L));
        vecs.push_back(make_vec(L, L, 16'd0, H, 128'h22, L,  H, 128'h21, L, H, L, L));
        vecs.push_back(make_vec(H, L, 16'd3, L, 128'h0,  L,  H, 128'h21, L, H, L, L));
        vecs.push_back(make_vec(L, H, 16'd0, H, 128'h55, L,  H, 128'h21, L, H, L, L));
        vecs.push_back(make_vec(L, L, 16'd0, L, 128'h0,  H,  H, 128'h22, H, H, L, L));
        vecs.push_back(make_vec(L, L, 16'd0, L, 128'h0,  H,  L, 128'h0,  L, L, H, L));
        vecs.push_back(make_vec(L, L, 16'd0, L, 128'h0,  H,  L, 128'h0,  L, L, L, L));
        // len=1: trigger word is the whole packet, controller back to IDLE
        vecs.push_back(make_vec(H, L, 16'd1, L, 128'h0,  L,  L, 128'h0,  L, H, L, L));
        vecs.push_back(make_vec(L, H, 16'd0, H, 128'hAA, L,  H, 128'hAA, H, H, L, L));
        vecs.push_back(make_vec(L, H, 16'd0, H, 128'hBB, H,  L, 128'h0,  L, L, H, L));
        vecs.push_back(make_vec(L, L, 16'd0, L, 128'h0,  H,  L, 128'h0,  L, L, L, L));

        // ---------------- reset state ----------------
        rst = 1'b1;
        applyStimulus(L, L, '0, L, '0, L);
        repeat (3) tick();
        check_bit("reset tvalid", m_axis.tvalid, L);
        check_bit("reset tlast", m_axis.tlast, L);
        checkOutput("reset tdata", m_axis.tdata, '0);
        check_bit("reset busy", busy, L);
        check_bit("reset done", done, L);
        check_bit("reset overflow", overflow, L);
        checkOutput("reset trig_timestamp", DATA_W'(trig_timestamp), '0);
        rst = 1'b0;
        tick();

        // ---------------- table vectors ----------------
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].arm, vecs[i].trigger, vecs[i].len,
                          vecs[i].valid, vecs[i].data, vecs[i].ready);
            tick();
            check_bit($sformatf("vec%0d tvalid", i), m_axis.tvalid, vecs[i].e_tvalid);
            checkOutput($sformatf("vec%0d tdata", i), m_axis.tdata, vecs[i].e_tdata);
            check_bit($sformatf("vec%0d tlast", i), m_axis.tlast, vecs[i].e_tlast);
            check_bit($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
            check_bit($sformatf("vec%0d done", i), done, vecs[i].e_done);
            check_bit($sformatf("vec%0d overflow", i), overflow, vecs[i].e_ovf);
        end

        // ---------------- trigger on arm cycle ignored, later trigger taken ----------------
        applyStimulus(H, H, 16'd2, H, 128'h0F, H);
        tick();
        check_bit("armtrig busy", busy, H);
        check_bit("armtrig tvalid", m_axis.tvalid, L);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(L, L, '0, H, 128'h0E, H);
            tick();
            check_bit($sformatf("armtrig wait%0d tvalid", c), m_axis.tvalid, L);
        end
        snap_ts = ref_ts;
        applyStimulus(L, H, '0, H, 128'h10, L);
        tick();
        checkOutput("armtrig timestamp", DATA_W'(trig_timestamp), DATA_W'(snap_ts));
        check_bit("armtrig first tvalid", m_axis.tvalid, H);
        checkOutput("armtrig first data", m_axis.tdata, 128'h10);
        applyStimulus(L, L, '0, H, 128'h11, L);
        tick();
        exp_q = {128'h10, 128'h11};
        collect_packet("armtrig");

        // ---------------- overflow: len=20 into an 8-deep FIFO ----------------
        applyStimulus(H, L, 16'd20, L, '0, L);
        tick();
        check_bit("ovf armed busy", busy, H);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(L, k == 1, '0, H, DATA_W'(k), L);
            tick();
            if (k == 8) check_bit("ovf full not yet set", overflow, L);
        end
        check_bit("ovf set", overflow, H);
        checkOutput("ovf head data", m_axis.tdata, 128'h1);
        check_bit("ovf busy", busy, H);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(L, L, '0, H, 128'hEE, L);
            tick();
        end
        check_bit("ovf sticky while held", overflow, H);
        exp_q = {};
        for (int k = 1; k <= 8; k++) exp_q.push_back(DATA_W'(k));
        exp_q.push_back('0);
        collect_packet("ovf");
        check_bit("ovf sticky after drain", overflow, H);

        // ---------------- reset mid-capture ----------------
        applyStimulus(H, L, 16'd10, L, '0, L);
        tick();
        check_bit("midrst arm clears overflow", overflow, L);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(L, k == 0, '0, H, DATA_W'(8'h31 + k), L);
            tick();
        end
        check_bit("midrst holding data", m_axis.tvalid, H);
        rst = 1'b1;
        tick();
        check_bit("midrst tvalid", m_axis.tvalid, L);
        check_bit("midrst tlast", m_axis.tlast, L);
        checkOutput("midrst tdata", m_axis.tdata, '0);
        check_bit("midrst busy", busy, L);
        check_bit("midrst done", done, L);
        checkOutput("midrst trig_timestamp", DATA_W'(trig_timestamp), '0);
        rst = 1'b0;
        applyStimulus(L, L, '0, L, '0, L);
        tick();
        check_bit("midrst still empty", m_axis.tvalid, L);
        applyStimulus(H, L, 16'd2, L, '0, L);
        tick();
        snap_ts = ref_ts;
        applyStimulus(L, H, '0, H, 128'h61, L);
        tick();
        checkOutput("midrst new timestamp", DATA_W'(trig_timestamp), DATA_W'(snap_ts));
        applyStimulus(L, L, '0, H, 128'h62, L);
        tick();
        exp_q = {128'h61, 128'h62};
        collect_packet("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
